axi_wr_arbiter: RTL and testbench

Shares one AXI write-channel slave (AW/W/B) between N_MST requesting masters.

---
 rtl/axi_common_pkg.sv | 34 +++
 rtl/axi_rr_arbiter.sv | 26 ++
 rtl/axi_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_axi_wr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_common_pkg.sv
// rtl/axi_common_pkg.sv - shared AXI write-channel types, widths and payload packing helper
package axi_common;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 8;
    // awpld layout is {addr, len, size, burst}; len sits above the 5 size/burst bits
    localparam int AW_LEN_LSB = 5;

    typedef enum logic [2:0] {
        SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
    } brust_size_t;

    typedef enum logic [1:0] {
        FIXED_BRUSTT, INCR_BRUSTT, WRAP_BRUSTT, RSVD_BRUSTT
    } brust_type_t;

    typedef enum logic [1:0] {
        OKAY, EXOKAY, SLVERR, DECERR
    } resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE, ARB_AW, ARB_W, ARB_B
    } arb_state_t;

    function automatic logic [AXI_ADDR_W+AXI_LEN_W+4:0] aw_pack(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [AXI_LEN_W-1:0]  len,
        input brust_size_t           size,
        input brust_type_t           burst
    );
        return {addr, len, size, burst};
    endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - combinational round-robin pick: first request at/after ptr, wrapping
module axi_rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == '0 && req[(int'(ptr) + i) % N]) begin
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - round-robin sharing of one AXI write slave (AW/W/B) among N_MST masters
module axi_wr_arbiter
    import axi_common::*;
#(
    parameter int N_MST  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int AWP_W = ADDR_W + 8 + 3 + 2,
    localparam int WP_W  = DATA_W + DATA_W / 8,
    localparam int IDX_W = $clog2(N_MST)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_MST-1:0]       m_awvalid,
    output logic [N_MST-1:0]       m_awready,
    input  logic [N_MST*AWP_W-1:0] m_awpld,
    input  logic [N_MST-1:0]       m_wvalid,
    output logic [N_MST-1:0]       m_wready,
    input  logic [N_MST*WP_W-1:0]  m_wpld,
    input  logic [N_MST-1:0]       m_wlast,
    output logic [N_MST-1:0]       m_bvalid,
    input  logic [N_MST-1:0]       m_bready,
    output logic [N_MST*2-1:0]     m_bresp,
    output logic                   s_awvalid,
    input  logic                   s_awready,
    output logic [AWP_W-1:0]       s_awpld,
    output logic                   s_wvalid,
    input  logic                   s_wready,
    output logic [WP_W-1:0]        s_wpld,
    output logic                   s_wlast,
    input  logic                   s_bvalid,
    output logic                   s_bready,
    input  logic [1:0]             s_bresp,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   err_wlast
);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [AXI_LEN_W-1:0] awlen;
    logic [AXI_LEN_W-1:0] beat_cnt;

    logic [N_MST-1:0]     arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [AXI_LEN_W-1:0] req_len;
    logic                 aw_hs, w_hs, b_hs;

    axi_rr_arbiter #(.N(N_MST)) u_rr (
        .req (m_awvalid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        req_len = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (arb_gnt[i]) req_len = m_awpld[i*AWP_W + AW_LEN_LSB +: AXI_LEN_W];
        end
    end

    assign aw_hs   = (state == ARB_AW) && m_awvalid[gnt_idx] && s_awready;
    assign w_hs    = (state == ARB_W)  && m_wvalid[gnt_idx]  && s_wready;
    assign b_hs    = (state == ARB_B)  && s_bvalid           && m_bready[gnt_idx];
    assign s_wlast = (state == ARB_W)  && (beat_cnt == awlen);

    // Grant is taken only from registered state, so request inputs never reach gnt_idx combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            awlen     <= '0;
            beat_cnt  <= '0;
            err_wlast <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: if (arb_any) begin
                    gnt_idx <= arb_idx;
                    awlen   <= req_len;
                    state   <= ARB_AW;
                end
                ARB_AW: if (aw_hs) begin
                    beat_cnt <= '0;
                    state    <= ARB_W;
                end
                ARB_W: if (w_hs) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (m_wlast[gnt_idx] != s_wlast) err_wlast <= 1'b1;
                    if (s_wlast) state <= ARB_B;
                end
                ARB_B: if (b_hs) begin
                    ptr   <= (gnt_idx == IDX_W'(N_MST - 1)) ? '0 : gnt_idx + 1'b1;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_awpld   = m_awpld[gnt_idx*AWP_W +: AWP_W];
        s_wpld    = m_wpld[gnt_idx*WP_W +: WP_W];
        case (state)
            ARB_AW: begin
                s_awvalid          = m_awvalid[gnt_idx];
                m_awready[gnt_idx] = s_awready;
            end
            ARB_W: begin
                s_wvalid          = m_wvalid[gnt_idx];
                m_wready[gnt_idx] = s_wready;
            end
            ARB_B: begin
                m_bvalid[gnt_idx]          = s_bvalid;
                m_bresp[gnt_idx*2 +: 2]    = s_bresp;
                s_bready                   = m_bready[gnt_idx];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - scoreboard bench for axi_wr_arbiter with directed bursts
module tb_axi_wr_arbiter;
    import axi_common::*;

    localparam int N = 4, ADDR_W = 32, DATA_W = 32;
    localparam int AWP_W = ADDR_W + 13, WP_W = DATA_W + DATA_W / 8, IDX_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [N*AWP_W-1:0] m_awpld;
    logic [N*WP_W-1:0]  m_wpld;
    logic [N*2-1:0]     m_bresp;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [AWP_W-1:0] s_awpld;
    logic [WP_W-1:0]  s_wpld;
    logic [1:0]       s_bresp;
    logic [IDX_W-1:0] gnt_idx;
    logic             err_wlast;

    always #5 clk = ~clk;

    axi_wr_arbiter #(.N_MST(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awpld(m_awpld),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wpld(m_wpld), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awpld(s_awpld),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wpld(s_wpld), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .gnt_idx(gnt_idx), .err_wlast(err_wlast)
    );

    typedef struct { int len; int bad; int n; brust_type_t bt; } desc_t;
    typedef struct packed { logic [1:0] m; logic [AWP_W-1:0] pld; } aw_exp_t;
    typedef struct packed { logic [1:0] m; logic [WP_W-1:0] pld; logic last; } w_exp_t;
    typedef struct packed { logic [1:0] m; logic [1:0] resp; } b_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    b_exp_t  b_q[$];
    aw_exp_t ae;
    w_exp_t  we;
    b_exp_t  be;

    desc_t dq[N][$];
    desc_t cur[N];
    logic  aw_req[N];
    logic  active[N];
    int    mbeat[N];
    int    nb[N];
    resp_t sresp_q[$];
    logic  w_toggle = 1'b0;
    int    b_delay = 0;
    logic  b_pend = 1'b0;
    int    b_wait = 0;
    int    cyc = 0;
    int    start;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AWP_W-1:0] aw_of(input int m, input int n, input int len, input brust_type_t bt);
        return aw_pack(32'h1000_0000 + 32'(m * 256 + n), 8'(len), SIZE_4B, bt);
    endfunction

    function automatic logic [WP_W-1:0] w_of(input int m, input int n, input int beat);
        return {4'(m), 12'(n), 16'(beat), 4'hF};
    endfunction

    function automatic logic busy();
        logic b = 1'b0;
        for (int m = 0; m < N; m++) b = b | active[m] | (dq[m].size() != 0);
        return b;
    endfunction

    task automatic drive();
        for (int m = 0; m < N; m++) begin
            if (!active[m] && dq[m].size() != 0) begin
                cur[m]    = dq[m].pop_front();
                active[m] = 1'b1;
                aw_req[m] = 1'b1;
                mbeat[m]  = 0;
            end
            m_awvalid[m] = aw_req[m];
            m_awpld[m*AWP_W +: AWP_W] = aw_of(m, cur[m].n, cur[m].len, cur[m].bt);
            m_wvalid[m] = active[m] && (mbeat[m] <= cur[m].len);
            m_wpld[m*WP_W +: WP_W] = w_of(m, cur[m].n, mbeat[m]);
            m_wlast[m] = active[m] && (mbeat[m] == ((cur[m].bad < 0) ? cur[m].len : cur[m].bad));
            m_bready[m] = active[m];
        end
        s_awready = 1'b1;
        s_wready  = w_toggle ? cyc[0] : 1'b1;
        s_bvalid  = b_pend && (b_wait == 0);
        s_bresp   = (sresp_q.size() != 0) ? sresp_q[0] : OKAY;
    endtask

    task automatic update();
        for (int m = 0; m < N; m++) begin
            if (m_awvalid[m] && m_awready[m]) aw_req[m] = 1'b0;
            if (m_wvalid[m] && m_wready[m]) mbeat[m]++;
            if (m_bvalid[m] && m_bready[m]) active[m] = 1'b0;
        end
        if (s_wvalid && s_wready && s_wlast) begin
            b_pend = 1'b1;
            b_wait = b_delay;
        end else if (b_pend && b_wait > 0) begin
            b_wait--;
        end
        if (s_bvalid && s_bready) begin
            b_pend = 1'b0;
            if (sresp_q.size() != 0) void'(sresp_q.pop_front());
        end
    endtask

    // One window: inputs set at negedge, handshakes resolve at the following posedge
    task automatic cycle();
        @(negedge clk);
        drive();
        #3;
        if (!rst) update();
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int m = 0; m < N; m++) begin
            dq[m].delete();
            aw_req[m] = 1'b0;
            active[m] = 1'b0;
            mbeat[m]  = 0;
        end
        sresp_q.delete();
        aw_q.delete();
        w_q.delete();
        b_q.delete();
        b_pend = 1'b0;
        b_wait = 0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic issue(input int m, input int len, input int bad, input brust_type_t bt,
                         input resp_t r, input int nbeats);
        desc_t d;
        d.len = len; d.bad = bad; d.n = nb[m]; d.bt = bt;
        nb[m]++;
        dq[m].push_back(d);
        aw_q.push_back({2'(m), aw_of(m, d.n, len, bt)});
        for (int i = 0; i < nbeats; i++) w_q.push_back({2'(m), w_of(m, d.n, i), (i == len)});
        if (nbeats == len + 1) begin
            b_q.push_back({2'(m), 2'(r)});
            sresp_q.push_back(r);
        end
    endtask

    task automatic run(input int maxc);
        int k = 0;
        while (busy() && k < maxc) begin
            cycle();
            k++;
        end
        check("timeout", busy(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_handshake"}, {s_awvalid, s_wvalid, s_wlast, s_bready}, 0);
        check({tag, "_m_handshake"}, {m_awready, m_wready, m_bvalid}, 0);
        check({tag, "_gnt_idx"}, gnt_idx, 0);
        check({tag, "_err_wlast"}, err_wlast, 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (s_awvalid && s_awready) begin
                check("aw_expected", aw_q.size() != 0, 1);
                if (aw_q.size() != 0) begin
                    ae = aw_q.pop_front();
                    check("aw_gnt", gnt_idx, ae.m);
                    check("aw_pld", s_awpld, ae.pld);
                end
            end
            if (s_wvalid && s_wready) begin
                check("w_expected", w_q.size() != 0, 1);
                if (w_q.size() != 0) begin
                    we = w_q.pop_front();
                    check("w_gnt", gnt_idx, we.m);
                    check("w_pld", s_wpld, we.pld);
                    check("w_last", s_wlast, we.last);
                end
            end
            if ((m_bvalid & m_bready) != 0) begin
                check("b_expected", b_q.size() != 0, 1);
                if (b_q.size() != 0) begin
                    be = b_q.pop_front();
                    check("b_onehot", m_bvalid, 4'b0001 << be.m);
                    check("b_resp", m_bresp[be.m*2 +: 2], be.resp);
                    check("b_gnt", gnt_idx, be.m);
                end
            end
        end
    end

    initial begin
        for (int m = 0; m < N; m++) begin
            aw_req[m] = 1'b0; active[m] = 1'b0; mbeat[m] = 0; nb[m] = 0;
            cur[m].len = 0; cur[m].bad = -1; cur[m].n = 0; cur[m].bt = INCR_BRUSTT;
        end

        // Reset held with every master requesting
        for (int m = 0; m < N; m++) aw_req[m] = 1'b1;
        cycle();
        check_idle_outputs("rst_c1");
        cycle();
        check_idle_outputs("rst_c2");
        do_reset(1);

        // m0 INCR awlen=3, zero waits
        issue(0, 3, -1, INCR_BRUSTT, OKAY, 4);
        start = cyc;
        cycle();
        check("t1_c1_awvalid", s_awvalid, 0);
        cycle();
        check("t1_c2_awvalid", s_awvalid, 1);
        check("t1_c2_gnt", gnt_idx, 0);
        check("t1_c2_no_early_w", {s_wvalid, m_wready}, 0);
        run(50);
        check("t1_cycles", cyc - start, 7);

        // All four masters, m0 requests again after its first burst
        do_reset(1);
        issue(0, 1, -1, INCR_BRUSTT, EXOKAY, 2);
        issue(1, 0, -1, FIXED_BRUSTT, OKAY, 1);
        issue(2, 2, -1, WRAP_BRUSTT, DECERR, 3);
        issue(3, 0, -1, INCR_BRUSTT, SLVERR, 1);
        issue(0, 0, -1, INCR_BRUSTT, OKAY, 1);
        start = cyc;
        run(100);
        check("t3_cycles", cyc - start, 23);

        // m2 raises WLAST early; error flag is sticky until reset
        do_reset(1);
        check("t4_err_clear", err_wlast, 0);
        issue(2, 3, 1, RSVD_BRUSTT, OKAY, 4);
        run(50);
        check("t4_err_set", err_wlast, 1);
        issue(1, 0, -1, INCR_BRUSTT, EXOKAY, 1);
        run(50);
        check("t4_err_held", err_wlast, 1);
        do_reset(1);
        check("t4_err_rst", err_wlast, 0);

        // Slave backpressure on W and late B; m1 wins over m3 from ptr=0
        w_toggle = 1'b1;
        b_delay  = 5;
        issue(1, 1, -1, INCR_BRUSTT, OKAY, 2);
        issue(3, 4, -1, WRAP_BRUSTT, SLVERR, 5);
        run(200);
        w_toggle = 1'b0;
        b_delay  = 0;

        // Reset mid-burst abandons it and returns ptr to 0
        do_reset(1);
        issue(2, 0, -1, INCR_BRUSTT, OKAY, 1);
        run(50);
        issue(1, 7, -1, INCR_BRUSTT, OKAY, 2);
        for (int k = 0; k < 50 && mbeat[1] < 2; k++) cycle();
        check("t6_beats_before_rst", mbeat[1], 2);
        check("t6_aw_drained", aw_q.size(), 0);
        check("t6_w_drained", w_q.size(), 0);
        do_reset(1);
        check_idle_outputs("t6_after_rst");
        issue(0, 0, -1, INCR_BRUSTT, OKAY, 1);
        issue(3, 0, -1, INCR_BRUSTT, DECERR, 1);
        run(50);

        repeat (2) cycle();
        check("end_aw_q", aw_q.size(), 0);
        check("end_w_q", w_q.size(), 0);
        check("end_b_q", b_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
